// File: rtl/move_input_pkg.sv
// Shared types and helpers for the move input conditioner.
// Contents: the press-FSM state encoding, the direction codes, a counter-width
// helper, and the conversions between a one-hot press vector, a direction
// code and an active-low move mask.
package move_input_pkg;

    localparam int unsigned NUM_BTN = 4;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_FIRE,
        S_WAIT_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    // Bits needed to hold the values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Press vector bit order is {down, up, left, right}, matching dir_t.
    function automatic dir_t dir_encode(input logic [NUM_BTN-1:0] press);
        dir_t d;
        d = DIR_RIGHT;
        if (press[1]) d = DIR_LEFT;
        if (press[2]) d = DIR_UP;
        if (press[3]) d = DIR_DOWN;
        return d;
    endfunction

    // Active-low mask with only the selected direction low.
    function automatic logic [NUM_BTN-1:0] dir_mask_n(input logic [1:0] code);
        logic [NUM_BTN-1:0] m;
        m = '1;
        m[code] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchroniser plus debounce filter for one active-low push-button.
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset (all flops to idle/released)
//   btn_n_i   raw asynchronous button level, active-low
//   stable_n  debounced level, registered
module button_debouncer
    import move_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n_i,
    output logic stable_n
);

    localparam int unsigned CW = cnt_width(SYNC_STAGES + DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced_c;
    logic                   stable_q, stable_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    assign synced_c = sync_q[SYNC_STAGES-1];
    assign stable_n = stable_q;

    // A mismatch must persist DEBOUNCE_CYCLES cycles; any matching cycle restarts it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (synced_c != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = synced_c;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_n_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/move_input_conditioner.sv
// Turns four raw active-low direction buttons into single active-low move
// pulses for the 2048 game FSM. Chords are rejected, holds never repeat, and
// a button held through reset is not taken as a press.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   btn_{right,left,up,down}_n          raw asynchronous buttons, active-low
//   mov_{right,left,up,down}            registered active-low move pulses
//   move_code                           last accepted direction (dir_t coding)
//   busy                                high whenever the FSM is not idle
module move_input_conditioner
    import move_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned PULSE_CYCLES    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_right_n,
    input  logic       btn_left_n,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    output logic       mov_right,
    output logic       mov_left,
    output logic       mov_up,
    output logic       mov_down,
    output logic [1:0] move_code,
    output logic       busy
);

    localparam int unsigned IW = cnt_width(SYNC_STAGES + DEBOUNCE_CYCLES);
    localparam int unsigned PW = cnt_width(PULSE_CYCLES);

    logic [NUM_BTN-1:0] btn_n_c;
    logic [NUM_BTN-1:0] stable_n_c;
    logic [NUM_BTN-1:0] press_c;

    state_t             state_q, state_d;
    logic [IW-1:0]      init_cnt_q, init_cnt_d;
    logic [PW-1:0]      pulse_cnt_q, pulse_cnt_d;
    logic [1:0]         move_code_q, move_code_d;
    logic [NUM_BTN-1:0] mov_q, mov_d;
    logic               busy_q, busy_d;

    assign btn_n_c = {btn_down_n, btn_up_n, btn_left_n, btn_right_n};
    assign press_c = ~stable_n_c;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debouncer #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .reset   (reset),
            .btn_n_i (btn_n_c[i]),
            .stable_n(stable_n_c[i])
        );
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            move_code_q <= 2'b00;
            mov_q       <= '1;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            move_code_q <= move_code_d;
            mov_q       <= mov_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic. INIT lasts as long as the debounce latency so a button
    // held through reset is already seen as pressed when WAIT_RELEASE starts.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        move_code_d = move_code_q;
        unique case (state_q)
            S_INIT: begin
                if (init_cnt_q == IW'(SYNC_STAGES + DEBOUNCE_CYCLES - 1)) begin
                    init_cnt_d = '0;
                    state_d    = S_WAIT_RELEASE;
                end else begin
                    init_cnt_d = init_cnt_q + IW'(1);
                end
            end
            S_IDLE: begin
                if ($onehot(press_c)) begin
                    move_code_d = dir_encode(press_c);
                    pulse_cnt_d = '0;
                    state_d     = S_FIRE;
                end else if (press_c != '0) begin
                    state_d = S_WAIT_RELEASE;
                end
            end
            S_FIRE: begin
                if (pulse_cnt_q == PW'(PULSE_CYCLES - 1)) begin
                    state_d = S_WAIT_RELEASE;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PW'(1);
                end
            end
            S_WAIT_RELEASE: begin
                if (&stable_n_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Output decode from the next state so the registered outputs track state_q.
    always_comb begin
        mov_d  = '1;
        busy_d = (state_d != S_IDLE);
        if (state_d == S_FIRE) begin
            mov_d = dir_mask_n(move_code_d);
        end
    end

    assign mov_right = mov_q[0];
    assign mov_left  = mov_q[1];
    assign mov_up    = mov_q[2];
    assign mov_down  = mov_q[3];
    assign move_code = move_code_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Scenario bench for move_input_conditioner with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, PULSE_CYCLES=3. Button vectors and vector bits are
// ordered {down, up, left, right}.
module tb_move_input_conditioner;

    localparam int NSCN = 6;
    localparam int NDRV = 23;
    localparam int NCHK = 38;

    typedef struct {
        int         scn;
        int         t;
        logic       rst;
        logic [3:0] btn_n;
    } drv_t;

    typedef struct {
        int         scn;
        int         t;
        logic [3:0] mov;
        logic [1:0] code;
        logic       busy;
    } chk_t;

    typedef struct {
        int         stamp;
        int         scn;
        int         t;
        logic [3:0] mov;
        logic [1:0] code;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_n;
    logic       mov_right, mov_left, mov_up, mov_down;
    logic [1:0] move_code;
    logic       busy;

    drv_t drv [NDRV];
    chk_t chk [NCHK];
    int   scn_len [NSCN];
    int   exp_low [NSCN][4];
    int   low_cnt [4];
    exp_t q [$];
    exp_t e;
    logic [3:0] mov_s;
    int   step;
    int   n_vec;
    int   n_err;

    move_input_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES   (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_right_n(btn_n[0]),
        .btn_left_n (btn_n[1]),
        .btn_up_n   (btn_n[2]),
        .btn_down_n (btn_n[3]),
        .mov_right  (mov_right),
        .mov_left   (mov_left),
        .mov_up     (mov_up),
        .mov_down   (mov_down),
        .move_code  (move_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        reset = 1'b1;
        btn_n = 4'hF;
        step  = 0;
        n_vec = 0;
        n_err = 0;

        scn_len = '{12, 30, 34, 24, 30, 50};
        for (int s = 0; s < NSCN; s++)
            for (int d = 0; d < 4; d++) exp_low[s][d] = 0;
        exp_low[1][0] = 3;   // right pulse
        exp_low[2][3] = 3;   // down pulse after bouncing
        exp_low[4][1] = 3;   // left only
        exp_low[5][2] = 4;   // 1 cycle cut short by reset + 3 after re-press

        // Drive events: after edge t of scenario scn.
        drv[0]  = '{0, 0, 1'b1, 4'hF};
        drv[1]  = '{0, 3, 1'b0, 4'hF};
        drv[2]  = '{1, 0, 1'b0, 4'hE};
        drv[3]  = '{1, 20, 1'b0, 4'hF};
        drv[4]  = '{2, 0, 1'b0, 4'h7};
        drv[5]  = '{2, 2, 1'b0, 4'hF};
        drv[6]  = '{2, 4, 1'b0, 4'h7};
        drv[7]  = '{2, 6, 1'b0, 4'hF};
        drv[8]  = '{2, 8, 1'b0, 4'h7};
        drv[9]  = '{2, 10, 1'b0, 4'hF};
        drv[10] = '{2, 12, 1'b0, 4'h7};
        drv[11] = '{2, 25, 1'b0, 4'hF};
        drv[12] = '{3, 0, 1'b0, 4'h9};
        drv[13] = '{3, 15, 1'b0, 4'hF};
        drv[14] = '{4, 0, 1'b0, 4'hD};
        drv[15] = '{4, 10, 1'b0, 4'hC};
        drv[16] = '{4, 20, 1'b0, 4'hF};
        drv[17] = '{5, 0, 1'b0, 4'hB};
        drv[18] = '{5, 7, 1'b1, 4'hB};
        drv[19] = '{5, 9, 1'b0, 4'hB};
        drv[20] = '{5, 20, 1'b0, 4'hF};
        drv[21] = '{5, 30, 1'b0, 4'hB};
        drv[22] = '{5, 42, 1'b0, 4'hF};

        // Expected outputs after edge t: {mov down..right, move_code, busy}.
        chk[0]  = '{0, 1, 4'hF, 2'd0, 1'b1};
        chk[1]  = '{0, 8, 4'hF, 2'd0, 1'b1};
        chk[2]  = '{0, 9, 4'hF, 2'd0, 1'b1};
        chk[3]  = '{0, 10, 4'hF, 2'd0, 1'b0};
        chk[4]  = '{0, 11, 4'hF, 2'd0, 1'b0};
        chk[5]  = '{1, 6, 4'hF, 2'd0, 1'b0};
        chk[6]  = '{1, 7, 4'hE, 2'd0, 1'b1};
        chk[7]  = '{1, 9, 4'hE, 2'd0, 1'b1};
        chk[8]  = '{1, 10, 4'hF, 2'd0, 1'b1};
        chk[9]  = '{1, 26, 4'hF, 2'd0, 1'b1};
        chk[10] = '{1, 27, 4'hF, 2'd0, 1'b0};
        chk[11] = '{2, 18, 4'hF, 2'd0, 1'b0};
        chk[12] = '{2, 19, 4'h7, 2'd3, 1'b1};
        chk[13] = '{2, 21, 4'h7, 2'd3, 1'b1};
        chk[14] = '{2, 22, 4'hF, 2'd3, 1'b1};
        chk[15] = '{2, 31, 4'hF, 2'd3, 1'b1};
        chk[16] = '{2, 32, 4'hF, 2'd3, 1'b0};
        chk[17] = '{3, 6, 4'hF, 2'd3, 1'b0};
        chk[18] = '{3, 7, 4'hF, 2'd3, 1'b1};
        chk[19] = '{3, 21, 4'hF, 2'd3, 1'b1};
        chk[20] = '{3, 22, 4'hF, 2'd3, 1'b0};
        chk[21] = '{4, 7, 4'hD, 2'd1, 1'b1};
        chk[22] = '{4, 9, 4'hD, 2'd1, 1'b1};
        chk[23] = '{4, 10, 4'hF, 2'd1, 1'b1};
        chk[24] = '{4, 16, 4'hF, 2'd1, 1'b1};
        chk[25] = '{4, 26, 4'hF, 2'd1, 1'b1};
        chk[26] = '{4, 27, 4'hF, 2'd1, 1'b0};
        chk[27] = '{5, 6, 4'hF, 2'd1, 1'b0};
        chk[28] = '{5, 7, 4'hB, 2'd2, 1'b1};
        chk[29] = '{5, 8, 4'hF, 2'd0, 1'b1};
        chk[30] = '{5, 16, 4'hF, 2'd0, 1'b1};
        chk[31] = '{5, 26, 4'hF, 2'd0, 1'b1};
        chk[32] = '{5, 27, 4'hF, 2'd0, 1'b0};
        chk[33] = '{5, 36, 4'hF, 2'd0, 1'b0};
        chk[34] = '{5, 37, 4'hB, 2'd2, 1'b1};
        chk[35] = '{5, 39, 4'hB, 2'd2, 1'b1};
        chk[36] = '{5, 40, 4'hF, 2'd2, 1'b1};
        chk[37] = '{5, 49, 4'hF, 2'd2, 1'b0};

        @(posedge clk);
        #1;

        for (int s = 0; s < NSCN; s++) begin
            for (int d = 0; d < 4; d++) low_cnt[d] = 0;
            for (int t = 0; t < scn_len[s]; t++) begin
                for (int i = 0; i < NDRV; i++) begin
                    if (drv[i].scn == s && drv[i].t == t) begin
                        reset = drv[i].rst;
                        btn_n = drv[i].btn_n;
                    end
                end
                for (int i = 0; i < NCHK; i++) begin
                    if (chk[i].scn == s && chk[i].t == t)
                        q.push_back('{step, s, t, chk[i].mov, chk[i].code, chk[i].busy});
                end

                @(negedge clk);
                mov_s = {mov_down, mov_up, mov_left, mov_right};

                n_vec++;
                if ($countones(~mov_s) > 1) begin
                    n_err++;
                    $display("FAIL mutex s%0d t%0d: mov=%b, required at most one low", s, t, mov_s);
                end
                for (int d = 0; d < 4; d++) if (!mov_s[d]) low_cnt[d]++;

                while (q.size() > 0 && q[0].stamp == step) begin
                    e = q.pop_front();
                    n_vec++;
                    if (mov_s !== e.mov || move_code !== e.code || busy !== e.busy) begin
                        n_err++;
                        $display("FAIL chk s%0d t%0d: mov=%b code=%b busy=%b, required mov=%b code=%b busy=%b",
                                 e.scn, e.t, mov_s, move_code, busy, e.mov, e.code, e.busy);
                    end
                end

                step++;
                @(posedge clk);
                #1;
            end

            for (int d = 0; d < 4; d++) begin
                n_vec++;
                if (low_cnt[d] != exp_low[s][d]) begin
                    n_err++;
                    $display("FAIL pulse_len s%0d dir%0d: %0d low cycles, required %0d",
                             s, d, low_cnt[d], exp_low[s][d]);
                end
            end
        end

        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/move_input_conditioner.md
Name: move_input_conditioner

Overview:
- Upstream stage of the 2048 game FSM. Conditions the four raw, asynchronous, active-low direction push-buttons into clean move commands.
- Per button: synchronise, then debounce. A press is accepted only when exactly one button is down, and each accepted press yields exactly one active-low pulse on the matching mov_* input of the game FSM.
- Holding a button, bouncing contacts or chording buttons never produces repeated or ambiguous moves.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per button (minimum 2).
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronised level must hold before it is accepted (10 ms at 50 MHz).
- PULSE_CYCLES, 1, cycles the selected mov_* output is held low per accepted press.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_right_n  in  1  raw button, active-low, asynchronous
- btn_left_n  in  1  raw button, active-low, asynchronous
- btn_up_n  in  1  raw button, active-low, asynchronous
- btn_down_n  in  1  raw button, active-low, asynchronous
- mov_right  out  1  active-low move pulse to game FSM
- mov_left  out  1  active-low move pulse to game FSM
- mov_up  out  1  active-low move pulse to game FSM
- mov_down  out  1  active-low move pulse to game FSM
- move_code  out  2  last accepted direction: 00 right, 01 left, 10 up, 11 down
- busy  out  1  high whenever state is not IDLE

Behaviour:
- One clock (clk); reset is synchronous and active-high. All flops, including synchronisers, clear on reset.
- Reset values:
  - mov_* = 1
  - move_code = 00
  - busy = 1
  - synchroniser flops = 1
  - debounced levels = 1
  - debounce counters = 0
  - state = INIT, with init counter 0
- Synchroniser: SYNC_STAGES-deep shift register per button.
- Debounce, per button:
  - If the synchronised level differs from the stable level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, the stable level takes the synchronised value and the counter clears.
  - Any cycle with matching levels clears the counter.
- Latency: a raw edge sampled at edge 0 appears in the stable level after edge SYNC_STAGES+DEBOUNCE_CYCLES. The mov_* output falls after edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- INIT state:
  - Counts SYNC_STAGES+DEBOUNCE_CYCLES cycles, then goes to WAIT_RELEASE.
  - Purpose: a button held through reset is never taken as a press.
- IDLE state:
  - Exactly one stable level low: latch the direction into move_code, clear the pulse counter, go to FIRE.
  - Two or more low in the same cycle: reject (no pulse, move_code unchanged), go to WAIT_RELEASE.
  - None low: stay in IDLE.
- FIRE state:
  - The mov_* output selected by move_code is 0; the other three are 1.
  - After PULSE_CYCLES cycles, go to WAIT_RELEASE.
  - Button changes during FIRE are ignored.
- WAIT_RELEASE state:
  - Go to IDLE only when all four stable levels are 1.
  - Extra buttons pressed meanwhile are ignored and must also be released before IDLE.
- mov_* outputs are registered, glitch-free and mutually exclusive: at most one is low in any cycle.
- Reset mid-operation: an abandoned pulse ends with mov_* = 1 after the reset edge, then the full INIT/WAIT_RELEASE sequence runs.
- Counter widths: $clog2(DEBOUNCE_CYCLES+SYNC_STAGES+1) for the debounce and init counters; $clog2(PULSE_CYCLES+1) for the pulse counter. No wrap is possible.

Decomposition:
- Package move_input_pkg:
  - enum state_t {S_INIT, S_IDLE, S_FIRE, S_WAIT_RELEASE}
  - enum dir_t {DIR_RIGHT=2'b00, DIR_LEFT=2'b01, DIR_UP=2'b10, DIR_DOWN=2'b11}
- Sub-module button_debouncer (synchroniser plus debounce counter, parameters SYNC_STAGES and DEBOUNCE_CYCLES, output stable_n), instantiated four times.
- The top holds only the press state machine.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PULSE_CYCLES=3.
1. Reset for 3 cycles, all buttons 1 → mov_*=1 throughout; busy=1 through INIT (6 cycles) plus 1 cycle of WAIT_RELEASE; then busy=0.
2. btn_right_n low cleanly for 20 cycles, then high → mov_right=0 for exactly 3 cycles starting 7 cycles after the press; move_code=00; a single pulse only; busy=0 again 7 cycles after release.
3. btn_down_n toggles every 2 cycles for 12 cycles, then stays low → no pulse during bouncing; one mov_down pulse 7 cycles after the final fall; move_code=11.
4. btn_up_n and btn_left_n fall in the same cycle, held 15 cycles → no mov_* pulse; move_code unchanged; busy stays 1 until both stable levels return high.
5. btn_left_n held, btn_right_n pressed 10 cycles later, then both released → only a mov_left pulse (move_code=01); no mov_right at any time.
6. Reset asserted during FIRE with btn_up_n held through and after reset → mov_up=1 from the next edge; no pulse while held; releasing then re-pressing gives one mov_up pulse 7 cycles after the re-press.
